// File: rtl/i2s_receive_if.sv
// AXI4-Stream bundle carrying captured I2S words out of the receiver.
interface i2s_receive_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/i2s_receive.sv
// I2S slave receiver: oversamples sck/ws/sd, deserialises L/R words and streams
// them out of a small FIFO as AXI4-Stream (left first, right with TLAST).
module i2s_receive #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          M_AXIS_ACLK,
    input  logic          M_AXIS_ARESET,
    input  logic          sck,
    input  logic          ws,
    input  logic          sd,
    i2s_receive_if.master m_axis,
    output logic          overrun
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] MaxFillForLeft = CntW'(FIFO_DEPTH - 2);
    localparam logic [BitW-1:0] WordBits = BitW'(DATA_WIDTH);

    typedef enum logic {StUnsync, StRun} state_e;

    state_e                state_q, state_d;
    logic [2:0]            sck_sync_q, sck_sync_d;
    logic [1:0]            ws_sync_q, ws_sync_d;
    logic [1:0]            sd_sync_q, sd_sync_d;
    logic                  ws_prev_q, ws_prev_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  commit_q, commit_d;
    logic                  commit_last_q, commit_last_d;
    logic [DATA_WIDTH-1:0] commit_word_q, commit_word_d;
    logic                  left_ok_q, left_ok_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;

    logic sck_rise, ws_bit, sd_bit, boundary, out_valid, fifo_wr, fifo_rd;

    // sync_q[1] is the synchronised level, sck_sync_q[2] its one-cycle history
    assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
    assign ws_bit    = ws_sync_q[1];
    assign sd_bit    = sd_sync_q[1];
    assign boundary  = sck_rise & (ws_bit != ws_prev_q);
    assign out_valid = (count_q != '0);
    assign fifo_rd   = out_valid & m_axis.tready;

    always_comb begin
        sck_sync_d    = {sck_sync_q[1:0], sck};
        ws_sync_d     = {ws_sync_q[0], ws};
        sd_sync_d     = {sd_sync_q[0], sd};
        state_d       = state_q;
        ws_prev_d     = ws_prev_q;
        bit_cnt_d     = bit_cnt_q;
        word_d        = word_q;
        commit_d      = 1'b0;
        commit_last_d = commit_last_q;
        commit_word_d = commit_word_q;
        if (sck_rise) begin
            ws_prev_d = ws_bit;
            if (state_q == StRun && bit_cnt_q < WordBits) begin
                word_d    = word_q | ({sd_bit, {(DATA_WIDTH - 1){1'b0}}} >> bit_cnt_q);
                bit_cnt_d = bit_cnt_q + BitW'(1);
            end
            // The boundary bit is the old channel's LSB, so it lands before the commit
            if (boundary) begin
                commit_d      = (state_q == StRun);
                commit_last_d = ws_prev_q;
                commit_word_d = word_d;
                word_d        = '0;
                bit_cnt_d     = '0;
                state_d       = StRun;
            end
        end
    end

    always_comb begin
        left_ok_d = left_ok_q;
        overrun_d = overrun_q;
        fifo_wr   = 1'b0;
        if (commit_q) begin
            if (!commit_last_q) begin
                // Only admit a left word when its right partner is sure to fit too
                if (count_q > MaxFillForLeft) begin
                    overrun_d = 1'b1;
                    left_ok_d = 1'b0;
                end else begin
                    fifo_wr   = 1'b1;
                    left_ok_d = 1'b1;
                end
            end else begin
                fifo_wr   = left_ok_q;
                left_ok_d = 1'b0;
            end
        end
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = {commit_last_q, commit_word_q};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({fifo_wr, fifo_rd})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            state_q       <= StUnsync;
            sck_sync_q    <= '0;
            ws_sync_q     <= '0;
            sd_sync_q     <= '0;
            ws_prev_q     <= 1'b0;
            bit_cnt_q     <= '0;
            word_q        <= '0;
            commit_q      <= 1'b0;
            commit_last_q <= 1'b0;
            commit_word_q <= '0;
            left_ok_q     <= 1'b0;
            overrun_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            sck_sync_q    <= sck_sync_d;
            ws_sync_q     <= ws_sync_d;
            sd_sync_q     <= sd_sync_d;
            ws_prev_q     <= ws_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            word_q        <= word_d;
            commit_q      <= commit_d;
            commit_last_q <= commit_last_d;
            commit_word_q <= commit_word_d;
            left_ok_q     <= left_ok_d;
            overrun_q     <= overrun_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

    assign m_axis.tvalid                = out_valid;
    assign {m_axis.tlast, m_axis.tdata} = mem_q[rd_ptr_q];
    assign overrun                      = overrun_q;
endmodule

// File: tb/tb_i2s_receive.sv
// Bench for i2s_receive: drives I2S frames and checks the AXI-Stream beats
// against a queue of expected words derived from the transmitted bit stream.
module tb_i2s_receive;
    localparam int unsigned DW    = 32;
    localparam int unsigned Depth = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sck = 1'b0;
    logic ws  = 1'b0;
    logic sd  = 1'b0;
    logic overrun;

    i2s_receive_if #(.DATA_WIDTH(DW)) axis ();

    i2s_receive #(.DATA_WIDTH(DW), .FIFO_DEPTH(Depth)) dut (
        .M_AXIS_ACLK  (clk),
        .M_AXIS_ARESET(rst),
        .sck          (sck),
        .ws           (ws),
        .sd           (sd),
        .m_axis       (axis),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_beats  = 0;
    int          rdy_mode = 0;  // 0 stall, 1 ready, 2 toggle, 3 random
    logic [32:0] exp_q[$];
    logic [63:0] tx_l[200];
    logic [63:0] tx_r[200];
    int          tx_frame = 0;
    int          tx_chan  = 0;
    int          tx_pos   = 0;
    bit          lsb_seen = 1'b0;
    longint      lsb_rise_t = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Word seen by a DW=32 receiver: the first min(slot,32) transmitted bits, left-aligned
    function automatic logic [31:0] exp_word(input logic [63:0] tx, input int slot);
        logic [31:0] top;
        top = tx[63:32];
        if (slot >= 32) return top;
        return top & ~(32'hFFFF_FFFF >> slot);
    endfunction

    task automatic sck_period(input logic w, input logic d, input int half, input bit mark);
        ws = w;
        sd = d;
        #(half);
        sck = 1'b1;
        if (mark) begin
            lsb_rise_t = longint'($time);
            lsb_seen   = 1'b1;
        end
        #(half);
        sck = 1'b0;
    endtask

    // I2S: ws leads the data by one bit, so each slot opens with the previous LSB
    task automatic send_stream(input int slot, input int nframes, input int half);
        logic        prev_bit;
        logic [63:0] cur;
        prev_bit = 1'b0;
        #($urandom_range(1, 9));
        for (int f = 0; f < nframes; f++) begin
            for (int c = 0; c < 2; c++) begin
                cur = (c == 0) ? tx_l[f] : tx_r[f];
                for (int p = 0; p < slot; p++) begin
                    tx_frame = f;
                    tx_chan  = c;
                    tx_pos   = p;
                    sck_period(c[0], (p == 0) ? prev_bit : cur[64-p], half,
                               (f == 1 && c == 1 && p == 0));
                end
                prev_bit = cur[64-slot];
            end
        end
        tx_frame = nframes;
        tx_chan  = 0;
        for (int p = 0; p < 6; p++) begin
            tx_pos = p;
            sck_period(1'b0, (p == 0) ? prev_bit : 1'b0, half, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2;
        check_eq("drained", exp_q.size(), 0);
        check_eq("beat_count", n_beats, n);
        check_eq("idle_valid", axis.tvalid, 1'b0);
    endtask

    task automatic push_frames(input int first, input int last, input int slot);
        for (int f = first; f <= last; f++) begin
            exp_q.push_back({1'b0, exp_word(tx_l[f], slot)});
            exp_q.push_back({1'b1, exp_word(tx_r[f], slot)});
        end
    endtask

    task automatic run_stream(input int slot, input int nframes, input int half, input int mode);
        do_reset();
        exp_q.delete();
        n_beats  = 0;
        rdy_mode = mode;
        lsb_seen = 1'b0;
        push_frames(1, nframes - 1, slot);
        fork
            send_stream(slot, nframes, half);
            begin : latency_watch
                bit     got;
                longint lat;
                got = 1'b0;
                wait (lsb_seen);
                for (int i = 0; i < 10 && !got; i++) begin
                    @(negedge clk);
                    #1;
                    got = axis.tvalid;
                end
                lat = longint'($time) - lsb_rise_t;
                check_eq("latency", got && (lat <= 56), 1'b1);
            end
        join
        wait_drain(2 * (nframes - 1));
        check_eq("no_overrun", overrun, 1'b0);
    endtask

    // Consumer: drives tready, checks accepted beats and stall stability
    initial begin : monitor
        bit          hold;
        logic [32:0] held;
        hold        = 1'b0;
        held        = '0;
        axis.tready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       axis.tready = 1'b0;
                1:       axis.tready = 1'b1;
                2:       axis.tready = ~axis.tready;
                default: axis.tready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check_eq("stall_valid", axis.tvalid, 1'b1);
                    check_eq("stall_stable", {axis.tlast, axis.tdata}, held);
                end
                if (axis.tvalid && axis.tready) begin
                    n_beats++;
                    if (exp_q.size() == 0) begin
                        check_eq("extra_beat", exp_q.size(), 1);
                    end else begin
                        check_eq("tdata", axis.tdata, exp_q[0][31:0]);
                        check_eq("tlast", axis.tlast, exp_q[0][32]);
                        void'(exp_q.pop_front());
                    end
                end
                hold = axis.tvalid && !axis.tready;
                held = {axis.tlast, axis.tdata};
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        #2;
        rst = 1'b1;
        #5;
        check_eq("rst_tvalid", axis.tvalid, 1'b0);
        check_eq("rst_tlast", axis.tlast, 1'b0);
        check_eq("rst_tdata", axis.tdata, 32'h0);
        check_eq("rst_overrun", overrun, 1'b0);

        // Fixed pattern, full 32-bit slots
        for (int f = 0; f < 4; f++) begin
            tx_l[f] = 64'hA5A5_0001_0000_0000;
            tx_r[f] = 64'h5A5A_8002_0000_0000;
        end
        run_stream(32, 4, 40, 1);

        // 24-bit words padded in 32-bit slots
        for (int f = 0; f < 3; f++) begin
            tx_l[f] = 64'h0000_0000_0012_3456 << 40;
            tx_r[f] = {$urandom() & 32'hFFFF_FF00, 32'h0};
        end
        run_stream(32, 3, 40, 1);

        // 16-bit slots: low bits must come back as zeros
        for (int f = 0; f < 4; f++) begin
            tx_l[f] = 64'hBEEF_0000_0000_0000;
            tx_r[f] = {$urandom(), $urandom()};
        end
        run_stream(16, 4, 40, 2);

        // 36-bit slots: bits past the word width are discarded
        for (int f = 0; f < 5; f++) begin
            tx_l[f] = {$urandom(), $urandom()};
            tx_r[f] = {$urandom(), $urandom()};
        end
        run_stream(36, 5, 41, 3);

        // Overrun: consumer stalled for four frames, then drains with toggling ready
        do_reset();
        for (int f = 0; f < 5; f++) begin
            tx_l[f] = {$urandom(), $urandom()};
            tx_r[f] = {$urandom(), $urandom()};
        end
        exp_q.delete();
        n_beats  = 0;
        rdy_mode = 0;
        push_frames(1, 2, 16);
        send_stream(16, 5, 40);
        repeat (4) @(negedge clk);
        #2;
        check_eq("ovr_set", overrun, 1'b1);
        check_eq("ovr_valid", axis.tvalid, 1'b1);
        check_eq("ovr_head", {axis.tlast, axis.tdata}, {1'b0, exp_word(tx_l[1], 16)});
        rdy_mode = 2;
        wait_drain(4);
        check_eq("ovr_sticky", overrun, 1'b1);

        // Asynchronous reset in the middle of a right word
        do_reset();
        check_eq("ovr_cleared", overrun, 1'b0);
        for (int f = 0; f < 6; f++) begin
            tx_l[f] = {$urandom(), $urandom()};
            tx_r[f] = {$urandom(), $urandom()};
        end
        exp_q.delete();
        n_beats  = 0;
        rdy_mode = 0;
        fork
            send_stream(16, 6, 40);
            begin : mid_reset
                wait (tx_frame == 2 && tx_chan == 1 && tx_pos == 5);
                #3;
                check_eq("pre_rst_valid", axis.tvalid, 1'b1);
                rst = 1'b1;
                #1;
                check_eq("arst_tvalid", axis.tvalid, 1'b0);
                check_eq("arst_tlast", axis.tlast, 1'b0);
                check_eq("arst_tdata", axis.tdata, 32'h0);
                check_eq("arst_overrun", overrun, 1'b0);
                wait (tx_pos == 12);
                rst = 1'b0;
                push_frames(3, 5, 16);
                rdy_mode = 1;
            end
        join
        wait_drain(6);

        // Long random run with random ready and random sck rate/phase
        for (int f = 0; f < 120; f++) begin
            tx_l[f] = {$urandom(), $urandom()};
            tx_r[f] = {$urandom(), $urandom()};
        end
        run_stream(16, 120, int'($urandom_range(40, 44)), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
